// File: rtl/countdown_timer.sv
// countdown_timer: 1 Hz BCD HH:MM:SS countdown with field editing in SET,
// pause/resume, and a timed alarm window after reaching zero.
`default_nettype none

module countdown_timer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  model,
  input  logic [1:0]  adjust_shif,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        pause,
  input  logic        clear,
  output logic [23:0] countdown_num,
  output logic        run_led,
  output logic        expired,
  output logic        beep_req
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  typedef enum logic [1:0] {
    SET    = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ALARM  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   value_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [AW-1:0] alarm_cnt, alarm_nxt;
  logic          active;
  logic          tick;

  // One BCD field step with modular wrap between 00 and top; no carry out.
  function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic up,
                                          input logic [7:0] top);
    logic [7:0] r;
    if (up) begin
      if (f == top)              r = 8'h00;
      else if (f[3:0] == 4'd9)   r = {f[7:4] + 4'd1, 4'd0};
      else                       r = {f[7:4], f[3:0] + 4'd1};
    end else begin
      if (f == 8'h00)            r = top;
      else if (f[3:0] == 4'd0)   r = {f[7:4] - 4'd1, 4'd9};
      else                       r = {f[7:4], f[3:0] - 4'd1};
    end
    return r;
  endfunction

  // Whole-value decrement; the borrow chain only runs on a zero field below.
  function automatic logic [23:0] dec_time(input logic [23:0] v);
    logic [7:0] h, m, s;
    {h, m, s} = v;
    if (s == 8'h00) begin
      if (m == 8'h00) h = bcd_step(h, 1'b0, 8'h23);
      m = bcd_step(m, 1'b0, 8'h59);
    end
    s = bcd_step(s, 1'b0, 8'h59);
    return {h, m, s};
  endfunction

  assign active = (model == 2'b11);
  assign tick   = ((state == RUN) || (state == ALARM)) && (presc == PRESC_MAX);

  always_comb begin
    state_nxt = state;
    value_nxt = countdown_num;
    presc_nxt = presc;
    alarm_nxt = alarm_cnt;
    if (active && clear) begin
      state_nxt = SET;
      value_nxt = '0;
      presc_nxt = '0;
      alarm_nxt = '0;
    end else begin
      case (state)
        SET: begin
          if (active && pause && (countdown_num != '0)) begin
            state_nxt = RUN;
            presc_nxt = '0;
          end else if (active && (key_up ^ key_down)) begin
            case (adjust_shif)
              2'b00:   value_nxt[7:0]   = bcd_step(countdown_num[7:0],   key_up, 8'h59);
              2'b01:   value_nxt[15:8]  = bcd_step(countdown_num[15:8],  key_up, 8'h59);
              2'b10:   value_nxt[23:16] = bcd_step(countdown_num[23:16], key_up, 8'h23);
              default: value_nxt = countdown_num;
            endcase
          end
        end
        RUN: begin
          // Dropping pause freezes both value and prescaler, even on a tick cycle.
          if (active && !pause) begin
            state_nxt = PAUSED;
          end else begin
            presc_nxt = tick ? '0 : presc + 1'b1;
            if (tick) begin
              value_nxt = dec_time(countdown_num);
              if (countdown_num == 24'h000001) begin
                state_nxt = ALARM;
                alarm_nxt = '0;
              end
            end
          end
        end
        PAUSED: begin
          if (active && pause) state_nxt = RUN;
        end
        ALARM: begin
          presc_nxt = tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (alarm_cnt == ALARM_LAST) begin
              state_nxt = SET;
              alarm_nxt = '0;
            end else begin
              alarm_nxt = alarm_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = SET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SET;
      countdown_num <= '0;
      presc         <= '0;
      alarm_cnt     <= '0;
      run_led       <= 1'b0;
      expired       <= 1'b0;
      beep_req      <= 1'b0;
    end else begin
      state         <= state_nxt;
      countdown_num <= value_nxt;
      presc         <= presc_nxt;
      alarm_cnt     <= alarm_nxt;
      run_led       <= (state_nxt == RUN);
      expired       <= (state_nxt == ALARM);
      beep_req      <= (state_nxt == ALARM);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus random stimulus, compared each
// cycle against a seconds-based reference model of the countdown timer.
`default_nettype none

module tb_countdown_timer;

  localparam int CF = 10;
  localparam int AS = 10;
  localparam int M_SET = 0, M_RUN = 1, M_PAUSED = 2, M_ALARM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  model, adjust_shif;
  logic        key_up, key_down, pause, clear;
  logic [23:0] countdown_num;
  logic        run_led, expired, beep_req;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining time as plain seconds.
  int m_state, m_secs, m_presc, m_alarm;

  countdown_timer #(.CLK_FREQ(CF), .ALARM_SECS(AS)) dut (
    .clk(clk), .rst_n(rst_n), .model(model), .adjust_shif(adjust_shif),
    .key_up(key_up), .key_down(key_down), .pause(pause), .clear(clear),
    .countdown_num(countdown_num), .run_led(run_led), .expired(expired),
    .beep_req(beep_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_state = M_SET; m_secs = 0; m_presc = 0; m_alarm = 0;
  endtask

  task automatic model_step();
    bit act, tk;
    int h, m, s, d;
    act = (model == 2'b11);
    tk  = (m_state == M_RUN || m_state == M_ALARM) && (m_presc == CF - 1);
    if (act && clear) begin
      model_reset();
      return;
    end
    case (m_state)
      M_SET: begin
        if (act && pause && m_secs != 0) begin
          m_state = M_RUN; m_presc = 0;
        end else if (act && (key_up != key_down) && adjust_shif != 2'b11) begin
          h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
          d = key_up ? 1 : -1;
          if (adjust_shif == 2'b00) s = (s + d + 60) % 60;
          else if (adjust_shif == 2'b01) m = (m + d + 60) % 60;
          else h = (h + d + 24) % 24;
          m_secs = h * 3600 + m * 60 + s;
        end
      end
      M_RUN: begin
        if (act && !pause) m_state = M_PAUSED;
        else if (tk) begin
          m_presc = 0;
          m_secs--;
          if (m_secs == 0) begin m_state = M_ALARM; m_alarm = 0; end
        end else m_presc++;
      end
      M_PAUSED: if (act && pause) m_state = M_RUN;
      default: begin
        if (tk) begin
          m_presc = 0;
          m_alarm++;
          if (m_alarm == AS) begin m_state = M_SET; m_alarm = 0; end
        end else m_presc++;
      end
    endcase
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (!rst_n) model_reset(); else model_step();
      @(posedge clk);
      #1;
      check("num",  {8'h0, countdown_num}, {8'h0, to_bcd(m_secs)});
      check("run",  {31'h0, run_led},  {31'h0, m_state == M_RUN});
      check("exp",  {31'h0, expired},  {31'h0, m_state == M_ALARM});
      check("beep", {31'h0, beep_req}, {31'h0, m_state == M_ALARM});
    end
  endtask

  task automatic press(input logic [1:0] adj, input bit up, input int n);
    adjust_shif = adj;
    for (int i = 0; i < n; i++) begin
      key_up = up; key_down = !up;
      cycles(1);
      key_up = 1'b0; key_down = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; model = 2'b11; adjust_shif = 2'b11;
    key_up = 1'b0; key_down = 1'b0; pause = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    check("rst_num", {8'h0, countdown_num}, 32'h0);
    check("rst_flags", {29'h0, run_led, expired, beep_req}, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Async reset mid-RUN at 00:05:03
    press(2'b01, 1'b1, 5);
    press(2'b00, 1'b1, 3);
    check("set_0503", {8'h0, countdown_num}, 32'h000503);
    pause = 1'b1;
    cycles(4);
    check("run_0503", {8'h0, countdown_num}, 32'h000503);
    check("run_led_on", {31'h0, run_led}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_num", {8'h0, countdown_num}, 32'h0);
    check("async_run", {31'h0, run_led}, 32'h0);
    model_reset();
    pause = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(1);

    // 00:00:03 countdown into alarm window
    press(2'b00, 1'b1, 3);
    pause = 1'b1;
    cycles(1);
    cycles(10); check("cd_2", {8'h0, countdown_num}, 32'h000002);
    cycles(10); check("cd_1", {8'h0, countdown_num}, 32'h000001);
    check("cd_1_noexp", {31'h0, expired}, 32'h0);
    cycles(10); check("cd_0", {8'h0, countdown_num}, 32'h000000);
    check("alarm_exp", {30'h0, expired, beep_req}, 32'h3);
    cycles(AS * CF - 1);
    check("alarm_hold", {31'h0, beep_req}, 32'h1);
    cycles(1);
    check("alarm_end", {30'h0, expired, beep_req}, 32'h0);
    check("alarm_set", {31'h0, run_led}, 32'h0);

    // Field wraps in SET
    pause = 1'b0;
    press(2'b00, 1'b0, 1); check("sec_wrap", {8'h0, countdown_num}, 32'h000059);
    press(2'b10, 1'b0, 1); check("hr_dn_wrap", {8'h0, countdown_num}, 32'h230059);
    press(2'b10, 1'b1, 1); check("hr_up_wrap", {8'h0, countdown_num}, 32'h000059);
    adjust_shif = 2'b00; key_up = 1'b1; key_down = 1'b1;
    cycles(1);
    key_up = 1'b0; key_down = 1'b0;
    check("both_keys", {8'h0, countdown_num}, 32'h000059);
    press(2'b11, 1'b1, 1); check("adj_none", {8'h0, countdown_num}, 32'h000059);
    press(2'b01, 1'b0, 1); check("min_wrap", {8'h0, countdown_num}, 32'h005959);

    // Borrow chain and pause/resume from 01:00:00
    clear = 1'b1; cycles(1); clear = 1'b0;
    check("clear_zero", {8'h0, countdown_num}, 32'h0);
    press(2'b10, 1'b1, 1);
    pause = 1'b1;
    cycles(1);
    cycles(10); check("borrow", {8'h0, countdown_num}, 32'h005959);
    cycles(3);
    pause = 1'b0;
    cycles(25);
    check("frozen", {8'h0, countdown_num}, 32'h005959);
    check("paused_led", {31'h0, run_led}, 32'h0);
    pause = 1'b1;
    cycles(1);
    cycles(6); check("resume_wait", {8'h0, countdown_num}, 32'h005959);
    cycles(1); check("resume_dec", {8'h0, countdown_num}, 32'h005958);

    // Mode gating: background counting, keys/clear/pause ignored
    model = 2'b00; pause = 1'b0; key_up = 1'b1; adjust_shif = 2'b00;
    cycles(1);
    key_up = 1'b0; clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    cycles(18);
    check("gate_run", {31'h0, run_led}, 32'h1);
    check("gate_val", {8'h0, countdown_num}, 32'h005956);
    model = 2'b11; pause = 1'b1;
    cycles(1);
    check("gate_back", {8'h0, countdown_num}, 32'h005956);

    // pause with zero value stays in SET
    clear = 1'b1; cycles(1); clear = 1'b0;
    cycles(3);
    check("zero_set", {31'h0, run_led}, 32'h0);

    // clear coincident with the final tick
    pause = 1'b0;
    press(2'b00, 1'b1, 1);
    pause = 1'b1;
    cycles(1);
    cycles(9);
    check("pre_final", {8'h0, countdown_num}, 32'h000001);
    clear = 1'b1; cycles(1); clear = 1'b0;
    check("clr_tick_val", {8'h0, countdown_num}, 32'h0);
    check("clr_tick_exp", {30'h0, expired, run_led}, 32'h0);
    pause = 1'b0;
    cycles(5);
    check("clr_tick_after", {31'h0, expired}, 32'h0);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      key_up   = (r < 15);
      key_down = (r >= 10 && r < 25);
      clear    = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) < 6) pause = ~pause;
      model       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      adjust_shif = 2'($urandom_range(0, 3));
      if (i % 500 < 150) adjust_shif = 2'b00;
      cycles(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown-timer engine for display mode 2'b11 of the digital clock; runs beside stop_watch and time_counter.
- Consumes key_module's decoded controls (model, adjust_shif, key_up, key_down, pause, clear).
- Produces a BCD HH:MM:SS value for led_seg7_display and an expiry beep request for the buzzer path.
- Counts down at 1 Hz derived from clk; raises an alarm window on reaching zero.

Parameters:
- CLK_FREQ, 50_000_000, clk cycles per 1 s tick (set to 10 in simulation).
- ALARM_SECS, 10, seconds beep_req stays high after expiry.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- model  input  2  display mode; 2'b11 = countdown selected.
- adjust_shif  input  2  field select: 00 seconds, 01 minutes, 10 hours, 11 none.
- key_up  input  1  one-cycle pulse: increment the selected field.
- key_down  input  1  one-cycle pulse: decrement the selected field.
- pause  input  1  level: 1 = run, 0 = hold.
- clear  input  1  one-cycle pulse: abort and zero the timer.
- countdown_num  output  24  BCD {Ht,Hu,Mt,Mu,St,Su}.
- run_led  output  1  high while in RUN.
- expired  output  1  high while in ALARM.
- beep_req  output  1  buzzer request.

Behaviour:
- Reset, asynchronous: state SET, countdown_num = 0, prescaler = 0, alarm counter = 0, all outputs low.
- Gating: key_up, key_down, pause and clear act only when model == 2'b11. In any other mode these inputs are ignored and the state holds. A running countdown keeps counting in the background.
- Prescaler: counts 0..CLK_FREQ-1 only in RUN and ALARM. tick = 1 when prescaler == CLK_FREQ-1, and the prescaler then wraps to 0. The prescaler holds in PAUSED and is zeroed on entry to RUN from SET and on entry to ALARM.
- SET state:
  - key_up or key_down edits the selected field with modular wrap and no carry into the next field: sec/min 59<->00, hours 23<->00.
  - key_up and key_down in the same cycle: no change. adjust_shif == 11: no change.
  - pause == 1 and countdown_num != 0 -> RUN. pause == 1 with value 0: stay in SET.
- RUN state:
  - Each tick decrements by 1 s with a BCD borrow chain, e.g. 01:00:00 -> 00:59:59, 00:10:00 -> 00:09:59.
  - pause == 0 -> PAUSED; the value is frozen. Keys are ignored.
  - A tick that makes the value 00:00:00 -> ALARM on the same edge. countdown_num reads 0 and expired rises in the same cycle.
- PAUSED state: pause == 1 -> RUN with prescaler resumed, not zeroed. Keys are ignored.
- ALARM state:
  - beep_req = 1. The alarm counter counts ticks; after ALARM_SECS ticks -> SET with beep_req low.
  - pause has no effect.
- clear, in any state with model == 11: -> SET, value 0, prescaler 0, alarm counter 0 on the next edge.
- clear priority: clear beats tick, keys and pause in the same cycle.
- Outputs are registered. run_led = (state == RUN); expired = (state == ALARM); beep_req = expired.
- Latency: a control pulse takes effect on the next clk edge. The first decrement occurs exactly CLK_FREQ cycles after entering RUN from SET.
- countdown_num digits are never outside BCD range. The value is never above 23:59:59.

Test Plan:
- Reset mid-RUN at value 00:05:03: assert rst_n low -> outputs 0, state SET immediately (async).
- Set 00:00:03, model = 11, CLK_FREQ = 10, pause = 1:
  - countdown_num reads 00:00:02 / 01 / 00 at cycles +10 / +20 / +30 after start.
  - expired and beep_req rise at +30 and fall after ALARM_SECS * 10 more cycles; state returns to SET.
- Field wrap in SET:
  - adjust_shif = 00, key_down at 0 -> seconds 59, minutes unchanged.
  - adjust_shif = 10, key_up at 23 -> hours 00.
  - key_up and key_down together -> unchanged.
- Borrow and pause, starting from 01:00:00:
  - One tick -> 00:59:59.
  - pause = 0 for 25 cycles -> value frozen, run_led low.
  - pause = 1 -> next decrement occurs at the remaining prescaler count.
- Mode gating:
  - model = 00 while running -> decrements continue.
  - key_up and clear pulses are ignored.
  - Returning to model = 11 shows the advanced value.
- Edge cases:
  - pause = 1 with value 0 -> stays in SET, run_led low.
  - clear coincident with the final tick -> SET, value 0, expired never asserted.
